delta_frame_mc: RTL and testbench

Parametrised multi-channel frame-differencing stage for the motion/object-tracking pipeline. It sits between the pixel source plus background store and the blob/segmentation logic. Per pixel it forms per-channel absolute differences against the background, combines them (sum or max) and thresholds the result into a foreground mask. It also emits an exponentially updated background pixel for write-back and a per-frame foreground pixel count.

---
 rtl/delta_frame_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_delta_frame_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_frame_mc.sv
// Multi-channel frame-differencing stage: per-channel |o-bg|, sum/max combine, threshold mask,
// exponential background update and a per-frame foreground pixel counter.
module delta_frame_mc #(
  parameter  int unsigned PIX_W       = 8,
  parameter  int unsigned CHANNELS    = 3,
  parameter  int unsigned ALPHA_SHIFT = 3,
  parameter  int unsigned CNT_W       = 20,
  localparam int unsigned DIFF_W      = PIX_W + 2
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic                      in_eof,
  input  logic [CHANNELS*PIX_W-1:0] gray_o,
  input  logic [CHANNELS*PIX_W-1:0] gray_bg,
  input  logic                      mode,
  input  logic [DIFF_W-1:0]         threshold,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [DIFF_W-1:0]         diff_out,
  output logic                      mask_out,
  output logic [CHANNELS*PIX_W-1:0] bg_out,
  output logic [CNT_W-1:0]          fg_count,
  output logic                      fg_count_valid,
  output logic                      frame_err
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Stage 1 combinational per-channel math
  logic [PIX_W-1:0]        w_o      [CHANNELS];
  logic [PIX_W-1:0]        w_bgc    [CHANNELS];
  logic [PIX_W-1:0]        w_absd   [CHANNELS];
  logic [PIX_W-1:0]        w_bg_new [CHANNELS];
  logic signed [PIX_W:0]   w_delta  [CHANNELS];
  logic signed [PIX_W:0]   w_step   [CHANNELS];

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_o[c]      = gray_o[c*PIX_W +: PIX_W];
      w_bgc[c]    = gray_bg[c*PIX_W +: PIX_W];
      w_absd[c]   = (w_o[c] >= w_bgc[c]) ? (w_o[c] - w_bgc[c]) : (w_bgc[c] - w_o[c]);
      w_delta[c]  = $signed({1'b0, w_o[c]}) - $signed({1'b0, w_bgc[c]});
      w_step[c]   = w_delta[c] >>> ALPHA_SHIFT;
      // Result is known to fit in PIX_W bits, so the carry bit is simply dropped
      w_bg_new[c] = PIX_W'({1'b0, w_bgc[c]} + w_step[c]);
    end
  end

  // Frame configuration: the sof pixel itself already uses the new values
  logic              r_cfg_mode;
  logic [DIFF_W-1:0] r_cfg_thr;
  logic              w_cur_mode;
  logic [DIFF_W-1:0] w_cur_thr;

  assign w_cur_mode = in_sof ? mode      : r_cfg_mode;
  assign w_cur_thr  = in_sof ? threshold : r_cfg_thr;

  logic                      r1_valid;
  logic                      r1_sof;
  logic                      r1_eof;
  logic                      r1_mode;
  logic [DIFF_W-1:0]         r1_thr;
  logic [PIX_W-1:0]          r1_d [CHANNELS];
  logic [CHANNELS*PIX_W-1:0] r1_bg;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_cfg_mode <= 1'b0;
      r_cfg_thr  <= '0;
      r1_valid   <= 1'b0;
      r1_sof     <= 1'b0;
      r1_eof     <= 1'b0;
      r1_mode    <= 1'b0;
      r1_thr     <= '0;
      r1_bg      <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) r1_d[c] <= '0;
    end else begin
      r1_valid <= in_valid;
      r1_sof   <= in_valid & in_sof;
      r1_eof   <= in_valid & in_eof;
      if (in_valid) begin
        if (in_sof) begin
          r_cfg_mode <= mode;
          r_cfg_thr  <= threshold;
        end
        r1_mode <= w_cur_mode;
        r1_thr  <= w_cur_thr;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          r1_d[c]                  <= w_absd[c];
          r1_bg[c*PIX_W +: PIX_W]  <= w_bg_new[c];
        end
      end
    end
  end

  // Stage 2 combine and threshold
  logic [DIFF_W-1:0] w_sum;
  logic [PIX_W-1:0]  w_max;
  logic [DIFF_W-1:0] w_diff;
  logic              w_mask;

  always_comb begin
    w_sum = '0;
    w_max = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_sum = w_sum + DIFF_W'(r1_d[c]);
      if (r1_d[c] > w_max) w_max = r1_d[c];
    end
    w_diff = r1_mode ? DIFF_W'(w_max) : w_sum;
    w_mask = (w_diff > r1_thr);
  end

  logic                      r_out_valid;
  logic                      r_out_sof;
  logic                      r_out_eof;
  logic [DIFF_W-1:0]         r_diff;
  logic                      r_mask;
  logic [CHANNELS*PIX_W-1:0] r_bg_out;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_diff      <= '0;
      r_mask      <= 1'b0;
      r_bg_out    <= '0;
    end else begin
      r_out_valid <= r1_valid;
      r_out_sof   <= r1_sof;
      r_out_eof   <= r1_eof;
      if (r1_valid) begin
        r_diff   <= w_diff;
        r_mask   <= w_mask;
        r_bg_out <= r1_bg;
      end
    end
  end

  // Foreground counter FSM
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_fg_count, w_fg_count_nxt;
  logic             r_fg_valid, w_fg_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] w_mask_ext;
  logic [CNT_W-1:0] w_acc_inc;

  assign w_mask_ext = CNT_W'(r_mask);
  assign w_acc_inc  = (&r_acc) ? r_acc : (r_acc + w_mask_ext);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_fg_count <= '0;
      r_fg_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_fg_count <= w_fg_count_nxt;
      r_fg_valid <= w_fg_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_fg_count_nxt = r_fg_count;
    w_fg_valid_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    if (r_out_valid) begin
      case (r_state)
        S_IDLE: begin
          if (r_out_sof) begin
            w_acc_nxt = w_mask_ext;
            if (r_out_eof) begin
              w_fg_count_nxt = w_mask_ext;
              w_fg_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_ACTIVE;
            end
          end else if (r_out_eof) begin
            w_err_nxt = 1'b1;
          end
        end
        S_ACTIVE: begin
          // A sof without a closing eof restarts the count from this pixel
          if (r_out_sof) begin
            w_err_nxt = 1'b1;
            w_acc_nxt = w_mask_ext;
            if (r_out_eof) begin
              w_fg_count_nxt = w_mask_ext;
              w_fg_valid_nxt = 1'b1;
              w_state_nxt    = S_IDLE;
            end
          end else begin
            w_acc_nxt = w_acc_inc;
            if (r_out_eof) begin
              w_fg_count_nxt = w_acc_inc;
              w_fg_valid_nxt = 1'b1;
              w_state_nxt    = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_sof        = r_out_sof;
  assign out_eof        = r_out_eof;
  assign diff_out       = r_diff;
  assign mask_out       = r_mask;
  assign bg_out         = r_bg_out;
  assign fg_count       = r_fg_count;
  assign fg_count_valid = r_fg_valid;
  assign frame_err      = r_err;

endmodule

// File: tb/tb_delta_frame_mc.sv
// Directed self-checking bench for delta_frame_mc (3 channels, 8-bit, alpha 2^-3, 3-bit counter).
module tb_delta_frame_mc;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;
  logic [23:0] gray_o;
  logic [23:0] gray_bg;
  logic        mode;
  logic [9:0]  threshold;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [9:0]  diff_out;
  logic        mask_out;
  logic [23:0] bg_out;
  logic [2:0]  fg_count;
  logic        fg_count_valid;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  logic        cap_valid, cap_sof, cap_eof, cap_mask, cap_fgv, cap_err;
  logic [9:0]  cap_diff;
  logic [23:0] cap_bg;
  logic [2:0]  cap_fgc;

  delta_frame_mc #(
    .PIX_W      (8),
    .CHANNELS   (3),
    .ALPHA_SHIFT(3),
    .CNT_W      (3)
  ) dut (
    .clk_in        (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .in_eof        (in_eof),
    .gray_o        (gray_o),
    .gray_bg       (gray_bg),
    .mode          (mode),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .diff_out      (diff_out),
    .mask_out      (mask_out),
    .bg_out        (bg_out),
    .fg_count      (fg_count),
    .fg_count_valid(fg_count_valid),
    .frame_err     (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Samples outputs at the falling edge, then drives the next input cycle
  task automatic step(input logic rn, input logic v, input logic sf, input logic ef,
                      input logic [23:0] o, input logic [23:0] bg,
                      input logic md, input logic [9:0] th);
    @(negedge clk);
    cap_valid = out_valid;
    cap_sof   = out_sof;
    cap_eof   = out_eof;
    cap_diff  = diff_out;
    cap_mask  = mask_out;
    cap_bg    = bg_out;
    cap_fgc   = fg_count;
    cap_fgv   = fg_count_valid;
    cap_err   = frame_err;
    reset_n   = rn;
    in_valid  = v;
    in_sof    = sf;
    in_eof    = ef;
    gray_o    = o;
    gray_bg   = bg;
    mode      = md;
    threshold = th;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'h0, 1'b1, 10'h3FF);
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", cap_valid); end
    checks++; if (cap_diff !== 10'd0) begin failures++; $display("FAIL rst_diff got=%0d exp=0", cap_diff); end
    checks++; if (cap_bg !== 24'd0) begin failures++; $display("FAIL rst_bg got=%h exp=0", cap_bg); end
    checks++; if ({cap_mask, cap_fgv, cap_err, cap_sof, cap_eof} !== 5'b0) begin failures++;
      $display("FAIL rst_flags got=%b exp=00000", {cap_mask, cap_fgv, cap_err, cap_sof, cap_eof}); end
    checks++; if (cap_fgc !== 3'd0) begin failures++; $display("FAIL rst_fgc got=%0d exp=0", cap_fgc); end
    // Pixel before any sof: config must be sum mode, threshold 0 (ch0 diff 10, ch1 diff 5)
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'h00050A, 24'h0, 1'b1, 10'h3FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    checks++; if (cap_diff !== 10'd15) begin failures++; $display("FAIL precfg_diff got=%0d exp=15", cap_diff); end
    checks++; if (cap_mask !== 1'b1) begin failures++; $display("FAIL precfg_mask got=%0b exp=1", cap_mask); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    checks++; if (cap_err !== 1'b0) begin failures++; $display("FAIL precfg_err got=%0b exp=0", cap_err); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
  endtask

  task automatic test_single_channel();
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'd10,  24'd0,  1'b0, 10'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 24'd0,   24'd10, 1'b0, 10'd0);
    checks++; if (cap_valid !== 1'b0) begin failures++; $display("FAIL sc_latency got=%0b exp=0", cap_valid); end
    step(1'b1, 1'b1, 1'b0, 1'b1, 24'd255, 24'd0,  1'b0, 10'd0);
    checks++; if (cap_valid !== 1'b1 || cap_sof !== 1'b1) begin failures++;
      $display("FAIL sc_p0_valid got=%0b%0b exp=11", cap_valid, cap_sof); end
    checks++; if (cap_diff !== 10'd10) begin failures++; $display("FAIL sc_p0_diff got=%0d exp=10", cap_diff); end
    checks++; if (cap_bg !== 24'd1) begin failures++; $display("FAIL sc_p0_bg got=%0d exp=1", cap_bg); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
    checks++; if (cap_diff !== 10'd10) begin failures++; $display("FAIL sc_p1_diff got=%0d exp=10", cap_diff); end
    checks++; if (cap_bg !== 24'd8) begin failures++; $display("FAIL sc_p1_bg got=%0d exp=8", cap_bg); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
    checks++; if (cap_diff !== 10'd255) begin failures++; $display("FAIL sc_p2_diff got=%0d exp=255", cap_diff); end
    checks++; if (cap_bg !== 24'd31) begin failures++; $display("FAIL sc_p2_bg got=%0d exp=31", cap_bg); end
    checks++; if (cap_eof !== 1'b1 || cap_fgv !== 1'b0) begin failures++;
      $display("FAIL sc_p2_eof got=%0b%0b exp=10", cap_eof, cap_fgv); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
    checks++; if (cap_fgv !== 1'b1 || cap_fgc !== 3'd3) begin failures++;
      $display("FAIL sc_count got=%0b/%0d exp=1/3", cap_fgv, cap_fgc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
    checks++; if (cap_fgv !== 1'b0) begin failures++; $display("FAIL sc_pulse_len got=%0b exp=0", cap_fgv); end
  endtask

  // Same pixel as two back-to-back 1-pixel frames: sum mode then max mode
  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'h0032C8, 24'h646464, 1'b0, 10'd100);
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'h0032C8, 24'h646464, 1'b1, 10'd100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    checks++; if (cap_diff !== 10'd250 || cap_mask !== 1'b1) begin failures++;
      $display("FAIL sum_mode got=%0d/%0b exp=250/1", cap_diff, cap_mask); end
    checks++; if (cap_bg !== 24'h575D70) begin failures++; $display("FAIL bg_3ch got=%h exp=575d70", cap_bg); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    checks++; if (cap_diff !== 10'd100 || cap_mask !== 1'b0) begin failures++;
      $display("FAIL max_mode got=%0d/%0b exp=100/0", cap_diff, cap_mask); end
    checks++; if (cap_fgv !== 1'b1 || cap_fgc !== 3'd1) begin failures++;
      $display("FAIL b2b_cnt0 got=%0b/%0d exp=1/1", cap_fgv, cap_fgc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
    checks++; if (cap_fgv !== 1'b1 || cap_fgc !== 3'd0) begin failures++;
      $display("FAIL b2b_cnt1 got=%0b/%0d exp=1/0", cap_fgv, cap_fgc); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 10'd0);
  endtask

  // 8 pixels with gaps before pixels 3 and 6; mode/threshold change mid-frame must be ignored
  task automatic test_gap_frame();
    int so[10] = '{30, 5, 40, 255, 50, 10, 60, 255, 0, 25};
    int sv[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    int sm[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    int pulses = 0;
    int pulse_t = -1;
    logic [2:0] pulse_cnt = '0;
    logic [9:0] last_diff = '0;
    for (int t = 0; t < 15; t++) begin
      if (t < 10)
        step(1'b1, sv[t] != 0, t == 0, t == 9, {16'd0, 8'(so[t])}, 24'd0,
             (t >= 5), (t >= 5) ? 10'd0 : 10'd20);
      else
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
      if (t >= 2) begin
        int idx = t - 2;
        logic ev = (idx < 10) ? (sv[idx] != 0) : 1'b0;
        checks++; if (cap_valid !== ev) begin failures++;
          $display("FAIL gap_valid t=%0d got=%0b exp=%0b", t, cap_valid, ev); end
        if (ev) begin
          checks++; if (cap_diff !== 10'(so[idx]) || cap_mask !== (sm[idx] != 0)) begin failures++;
            $display("FAIL gap_pix t=%0d got=%0d/%0b exp=%0d/%0d", t, cap_diff, cap_mask, so[idx], sm[idx]); end
          last_diff = cap_diff;
        end else if (idx < 10) begin
          checks++; if (cap_diff !== last_diff) begin failures++;
            $display("FAIL gap_hold t=%0d got=%0d exp=%0d", t, cap_diff, last_diff); end
        end
      end
      if (cap_fgv === 1'b1 && t >= 2) begin
        pulses++;
        pulse_t = t;
        pulse_cnt = cap_fgc;
      end
    end
    checks++; if (pulses != 1 || pulse_t != 12) begin failures++;
      $display("FAIL gap_pulse got=%0d@%0d exp=1@12", pulses, pulse_t); end
    checks++; if (pulse_cnt !== 3'd5) begin failures++; $display("FAIL gap_count got=%0d exp=5", pulse_cnt); end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int pulse_t = -1;
    logic [2:0] pulse_cnt = '0;
    for (int t = 0; t < 16; t++) begin
      if (t < 12)
        step(1'b1, 1'b1, t == 0, t == 11, 24'd100, 24'd0, 1'b0, 10'd0);
      else
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 10'd0);
      if (cap_fgv === 1'b1 && t >= 2) begin
        pulses++;
        pulse_t = t;
        pulse_cnt = cap_fgc;
      end
    end
    checks++; if (pulses != 1 || pulse_t != 14) begin failures++;
      $display("FAIL sat_pulse got=%0d@%0d exp=1@14", pulses, pulse_t); end
    checks++; if (pulse_cnt !== 3'd7) begin failures++; $display("FAIL sat_count got=%0d exp=7", pulse_cnt); end
  endtask

  task automatic test_framing();
    int fv[16] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int fs[16] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int fe[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int fo[16] = '{50, 50, 50, 50, 50, 50, 50, 0, 0, 0, 50, 0, 0, 0, 0, 0};
    for (int t = 0; t < 16; t++) begin
      logic exp_err, exp_fgv;
      step(1'b1, fv[t] != 0, fs[t] != 0, fe[t] != 0, {16'd0, 8'(fo[t])}, 24'd0, 1'b0, 10'd0);
      exp_err = (t == 7) || (t == 13);
      exp_fgv = (t == 9) || (t == 14);
      if (t >= 2) begin
        checks++; if (cap_err !== exp_err) begin failures++;
          $display("FAIL frm_err t=%0d got=%0b exp=%0b", t, cap_err, exp_err); end
        checks++; if (cap_fgv !== exp_fgv) begin failures++;
          $display("FAIL frm_fgv t=%0d got=%0b exp=%0b", t, cap_fgv, exp_fgv); end
      end
      if (t == 9) begin
        checks++; if (cap_fgc !== 3'd3) begin failures++; $display("FAIL frm_restart_cnt got=%0d exp=3", cap_fgc); end
      end
      if (t == 14) begin
        checks++; if (cap_fgc !== 3'd0) begin failures++; $display("FAIL frm_1pix_cnt got=%0d exp=0", cap_fgc); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int rv[15] = '{1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
    int rs[15] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int re[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int ro[15] = '{50, 0, 0, 0, 50, 50, 50, 0, 50, 0, 60, 0, 0, 0, 0};
    for (int t = 0; t < 15; t++) begin
      logic exp_fgv;
      step(t != 7, rv[t] != 0, rs[t] != 0, re[t] != 0, {16'd0, 8'(ro[t])}, 24'd0, 1'b0, 10'd0);
      exp_fgv = (t == 3) || (t == 13);
      if (t >= 2) begin
        checks++; if (cap_fgv !== exp_fgv || cap_err !== 1'b0) begin failures++;
          $display("FAIL rmf_pulse t=%0d got=%0b%0b exp=%0b0", t, cap_fgv, cap_err, exp_fgv); end
      end
      if (t == 3) begin
        checks++; if (cap_fgc !== 3'd1) begin failures++; $display("FAIL rmf_pre_cnt got=%0d exp=1", cap_fgc); end
      end
      if (t == 8) begin
        checks++; if ({cap_valid, cap_sof, cap_eof, cap_mask} !== 4'b0 || cap_diff !== 10'd0
                      || cap_bg !== 24'd0 || cap_fgc !== 3'd0) begin failures++;
          $display("FAIL rmf_zero got=%b/%0d/%h/%0d exp=0000/0/0/0",
                   {cap_valid, cap_sof, cap_eof, cap_mask}, cap_diff, cap_bg, cap_fgc); end
      end
      if (t == 13) begin
        checks++; if (cap_fgc !== 3'd2) begin failures++; $display("FAIL rmf_post_cnt got=%0d exp=2", cap_fgc); end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_eof    = 1'b0;
    gray_o    = '0;
    gray_bg   = '0;
    mode      = 1'b0;
    threshold = '0;
    test_reset();
    test_single_channel();
    test_back_to_back();
    test_gap_frame();
    test_saturation();
    test_framing();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
